// File: rtl/vend_pkg.sv
// Shared constants for the candy vending sequencer: state encodings, coin values, coin-count helper.
package vend_pkg;

  localparam logic [2:0] ACCEPT = 3'd0;
  localparam logic [2:0] VEND   = 3'd1;
  localparam logic [2:0] CHANGE = 3'd2;
  localparam logic [2:0] FAULT  = 3'd3;
  localparam logic [2:0] REFUND = 3'd4;

  localparam int NICKLE_C = 5;
  localparam int DIME_C   = 10;
  localparam int QUATER_C = 25;

  function automatic logic [1:0] coin_count(input logic n, input logic d, input logic q);
    return {1'b0, n} + {1'b0, d} + {1'b0, q};
  endfunction

endpackage

// File: rtl/vend_ack_timer.sv
// Counts cycles a request waits for its ack; expired fires on the cycle the wait reaches ACK_TIMEOUT.
module vend_ack_timer #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  logic [TW-1:0] timer_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      timer_reg <= '0;
    end else if (clear) begin
      timer_reg <= '0;
    end else if (start) begin
      timer_reg <= timer_reg + 1'b1;
    end
  end

  // This edge would complete the ACK_TIMEOUT-th waiting cycle.
  assign expired = start && !clear && (timer_reg == TW'(ACK_TIMEOUT - 1));

endmodule

// File: rtl/vend_sequencer.sv
// Vending FSM: credit accumulation, dispense handshake, nickel change payout, ack timeout fault.
// Optional refund input and REFUND state are enabled with `define VEND_REFUND_EN.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int PRICE       = 25,
  parameter int CW          = 6,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          nickle,
  input  logic          dime,
  input  logic          quater,
  input  logic          vend_ack,
  input  logic          change_ack,
`ifdef VEND_REFUND_EN
  input  logic          refund,
`endif
  output logic          coin_inhibit,
  output logic          coin_reject,
  output logic          vend_req,
  output logic          change_req,
  output logic [CW-1:0] credit,
  output logic          fault
);

  logic [2:0]    state_reg, state_next;
  logic [CW-1:0] credit_reg, credit_next;
  logic          reject_reg, reject_next;
  logic [CW-1:0] coin_val;
  logic [CW-1:0] sum;
  logic          multi_coin;
  logic          expired;
  logic          timer_start;
  logic          timer_clear;

  always_comb begin
    coin_val = '0;
    case ({nickle, dime, quater})
      3'b100:  coin_val = CW'(NICKLE_C);
      3'b010:  coin_val = CW'(DIME_C);
      3'b001:  coin_val = CW'(QUATER_C);
      default: coin_val = '0;
    endcase
  end

  assign multi_coin = coin_count(nickle, dime, quater) > 2'd1;
  assign sum        = credit_reg + coin_val;

  always_comb begin
    state_next  = state_reg;
    credit_next = credit_reg;
    reject_next = 1'b0;
    case (state_reg)
      ACCEPT: begin
        if (multi_coin) begin
          reject_next = 1'b1;
        end else begin
          credit_next = sum;
        end
        // A coin that reaches the price wins over a simultaneous refund.
        if (!multi_coin && (sum >= CW'(PRICE))) begin
          state_next = VEND;
`ifdef VEND_REFUND_EN
        end else if (refund && (credit_next != '0)) begin
          state_next = REFUND;
`endif
        end
      end
      VEND: begin
        if (vend_ack) begin
          credit_next = credit_reg - CW'(PRICE);
          state_next  = (credit_reg == CW'(PRICE)) ? ACCEPT : CHANGE;
        end else if (expired) begin
          state_next = FAULT;
        end
      end
`ifdef VEND_REFUND_EN
      CHANGE, REFUND: begin
`else
      CHANGE: begin
`endif
        if (change_ack) begin
          credit_next = credit_reg - CW'(NICKLE_C);
          if (credit_reg == CW'(NICKLE_C)) begin
            state_next = ACCEPT;
          end
        end else if (expired) begin
          state_next = FAULT;
        end
      end
      FAULT: begin
        state_next = FAULT;
      end
      default: begin
        state_next  = ACCEPT;
        credit_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= ACCEPT;
      credit_reg <= '0;
      reject_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      credit_reg <= credit_next;
      reject_reg <= reject_next;
    end
  end

  assign vend_req     = (state_reg == VEND);
`ifdef VEND_REFUND_EN
  assign change_req   = (state_reg == CHANGE) || (state_reg == REFUND);
`else
  assign change_req   = (state_reg == CHANGE);
`endif
  assign coin_inhibit = (state_reg != ACCEPT);
  assign fault        = (state_reg == FAULT);
  assign credit       = credit_reg;
  assign coin_reject  = reject_reg;

  // An ack only counts while its own request is raised.
  assign timer_start = vend_req | change_req;
  assign timer_clear = (vend_req & vend_ack) | (change_req & change_ack);

  vend_ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .start  (timer_start),
    .clear  (timer_clear),
    .expired(expired)
  );

endmodule
